fetch_decode_queue: RTL and testbench

Parametrised, elastic fetch-to-decode pipeline buffer with valid/ready handshakes on both sides. It replaces a fixed single-entry stall/flush register with a DEPTH-entry in-order queue of arbitrary-width payloads, such as {instr, PC, PC+4}. Fetch pushes into the queue and decode pops from it. A synchronous flush discards everything in flight on a branch or jump redirect. The block sits between the fetch stage and the decode stage of the pipelined CPU.

---
 rtl/fetch_decode_queue.sv | 85 ++++++++
 tb/tb_fetch_decode_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Elastic in-order queue between fetch and decode. Valid/ready come only from
// registered occupancy, and a synchronous flush drops everything in flight.
module fetch_decode_queue #(
   parameter int                DATA_W = 96,
   parameter int                DEPTH  = 2,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [15:0]                  hold_cnt
);

   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [15:0]       r_hold_cnt;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign out_data  = w_empty ? BUBBLE : r_mem[r_rd_ptr];
   assign count     = r_count;
   assign hold_cnt  = r_hold_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt <= '0;
      end else if (out_valid && !out_ready && (r_hold_cnt != 16'hFFFF)) begin
         r_hold_cnt <= r_hold_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: a DEPTH=2 and a DEPTH=3 instance share
// stimulus; each scenario checks the instance it targets.
module tb_fetch_decode_queue;

   localparam logic [95:0] BUB3 = 96'h13;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [95:0] in_data;

   logic        d2_in_ready, d2_out_valid;
   logic [95:0] d2_out_data;
   logic [1:0]  d2_count;
   logic [15:0] d2_hold;

   logic        d3_in_ready, d3_out_valid;
   logic [95:0] d3_out_data;
   logic [1:0]  d3_count;
   logic [15:0] d3_hold;

   int n_tests = 0;
   int n_fail  = 0;

   logic [95:0] exp_q[$];

   always #5 clk = ~clk;

   fetch_decode_queue #(.DATA_W(96), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
      .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
      .count(d2_count), .hold_cnt(d2_hold)
   );

   fetch_decode_queue #(.DATA_W(96), .DEPTH(3), .BUBBLE(BUB3)) dut3 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(d3_in_ready), .in_data(in_data),
      .out_valid(d3_out_valid), .out_ready(out_ready), .out_data(d3_out_data),
      .count(d3_count), .hold_cnt(d3_hold)
   );

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic push(input logic [95:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      logic pred_push, pred_pop;

      // Reset and idle.
      do_reset();
      check("rst_count", 96'(d3_count), 96'd0);
      check("rst_valid", 96'(d3_out_valid), 96'd0);
      check("rst_ready", 96'(d3_in_ready), 96'd1);
      check("rst_data3", d3_out_data, BUB3);
      check("rst_data2", d2_out_data, 96'd0);
      check("rst_hold", 96'(d3_hold), 96'd0);

      // Two entries queued, then asynchronous reset mid-cycle.
      out_ready = 1'b0;
      push(96'hA1);
      push(96'hA2);
      check("pre_rst_cnt3", 96'(d3_count), 96'd2);
      check("pre_rst_cnt2", 96'(d2_count), 96'd2);
      check("pre_rst_rdy2", 96'(d2_in_ready), 96'd0);
      check("pre_rst_hold", 96'(d3_hold), 96'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_count", 96'(d3_count), 96'd0);
      check("arst_valid", 96'(d3_out_valid), 96'd0);
      check("arst_ready", 96'(d3_in_ready), 96'd1);
      check("arst_data", d3_out_data, BUB3);
      check("arst_hold", 96'(d3_hold), 96'd0);
      step();
      rst = 1'b0;
      step();
      step();
      check("idle_count", 96'(d3_count), 96'd0);
      check("idle_valid", 96'(d2_out_valid), 96'd0);
      check("idle_data", d2_out_data, 96'd0);

      // Streaming through DEPTH=2 with decode always ready.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 96'(i);
         step();
         check("stream_data", d2_out_data, 96'(i));
         check("stream_valid", 96'(d2_out_valid), 96'd1);
         check("stream_count", 96'(d2_count), 96'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drain", 96'(d2_count), 96'd0);
      check("stream_bubble", d2_out_data, 96'd0);

      // Backpressure on DEPTH=3.
      do_reset();
      out_ready = 1'b0;
      push(96'hA);
      push(96'hB);
      push(96'hC);
      check("full_ready", 96'(d3_in_ready), 96'd0);
      check("full_count", 96'(d3_count), 96'd3);
      check("full_head", d3_out_data, 96'hA);
      check("full_hold", 96'(d3_hold), 96'd2);
      step();
      check("stall_head", d3_out_data, 96'hA);
      check("stall_hold", 96'(d3_hold), 96'd3);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 96'hD;
      step();
      check("pop_full_head", d3_out_data, 96'hB);
      check("pop_full_count", 96'(d3_count), 96'd2);
      check("pop_full_ready", 96'(d3_in_ready), 96'd1);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check("d_count", 96'(d3_count), 96'd3);
      check("d_head", d3_out_data, 96'hB);
      check("d_hold", 96'(d3_hold), 96'd4);
      out_ready = 1'b1;
      step();
      check("order_c", d3_out_data, 96'hC);
      step();
      check("order_d", d3_out_data, 96'hD);
      check("order_d_cnt", 96'(d3_count), 96'd1);
      step();
      check("bp_empty", 96'(d3_out_valid), 96'd0);
      check("bp_bubble", d3_out_data, BUB3);
      check("bp_hold", 96'(d3_hold), 96'd4);

      // Flush beats a same-cycle push and pop.
      do_reset();
      push(96'h11);
      push(96'h22);
      check("fl_pre_count", 96'(d3_count), 96'd2);
      flush = 1'b1; in_valid = 1'b1; in_data = 96'h33; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("fl_count", 96'(d3_count), 96'd0);
      check("fl_valid", 96'(d3_out_valid), 96'd0);
      check("fl_data", d3_out_data, BUB3);
      check("fl_ready", 96'(d3_in_ready), 96'd1);
      check("fl_count2", 96'(d2_count), 96'd0);
      push(96'h44);
      check("fl_next_valid", 96'(d3_out_valid), 96'd1);
      check("fl_next_data", d3_out_data, 96'h44);
      check("fl_next_count", 96'(d3_count), 96'd1);

      // Wrap-around on DEPTH=3 with random decode readiness.
      do_reset();
      exp_q.delete();
      in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         in_data   = 96'h100 + 96'(i);
         out_ready = 1'($urandom_range(0, 1));
         pred_push = (exp_q.size() < 3);
         pred_pop  = (exp_q.size() != 0) && out_ready;
         step();
         if (pred_pop)  void'(exp_q.pop_front());
         if (pred_push) exp_q.push_back(in_data);
         check("wrap_count", 96'(d3_count), 96'(exp_q.size()));
         check("wrap_data", d3_out_data, (exp_q.size() != 0) ? exp_q[0] : BUB3);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0) begin
         step();
         void'(exp_q.pop_front());
         check("drain_data", d3_out_data, (exp_q.size() != 0) ? exp_q[0] : BUB3);
      end

      // hold_cnt saturation and immunity to flush.
      do_reset();
      out_ready = 1'b0;
      push(96'h55);
      check("sat_start", 96'(d3_hold), 96'd0);
      repeat (65534) step();
      check("sat_fffe", 96'(d3_hold), 96'hFFFE);
      repeat (3) step();
      check("sat_ffff3", 96'(d3_hold), 96'hFFFF);
      check("sat_ffff2", 96'(d2_hold), 96'hFFFF);
      check("sat_head", d3_out_data, 96'h55);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("sat_flush", 96'(d3_hold), 96'hFFFF);
      check("sat_flush_cnt", 96'(d3_count), 96'd0);
      step();
      check("sat_idle", 96'(d3_hold), 96'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
